seg7_readback_decoder: RTL
==========================

Name: seg7_readback_decoder

Overview:
- Readback monitor on the adder's display outputs.
- Samples the two 7-segment buses (sum digit and carry digit) and filters transients with a stability counter.
- Decodes settled patterns back to binary: 4-bit sum, 1-bit carry.
- Emits a one-cycle valid pulse per new result and an error level for illegal patterns. Used as an in-system checker and as the scoreboard front end in benches.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal range 1..255).
- ACTIVE_LOW, 1, 1 = a lit segment is driven 0 (common anode); 0 = a lit segment is driven 1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- seg_sum  input  7  sum digit segments; bit0=a ... bit6=g.
- seg_carry  input  7  carry digit segments; same bit order.
- sum_val  output  4  last accepted decoded sum digit.
- carry_val  output  1  last accepted decoded carry digit.
- valid  output  1  one-cycle pulse when sum_val/carry_val update.
- err  output  1  high while the last stable pattern is illegal.

Behaviour:
- Reset values: sum_val=0, carry_val=0, valid=0, err=0, state=IDLE, counter=0, sample registers=blank (all segments off for the selected polarity).
- Reset mid-settle discards all progress; no valid is produced for that pattern.
- Input stage: {seg_carry, seg_sum} is registered every cycle into samp. Previous samp is held in samp_d.
- Counter: if samp != samp_d, cnt<=0 and state=SETTLE; otherwise cnt saturates at STABLE_CYCLES.
- Acceptance: the pattern is accepted on the edge where cnt reaches STABLE_CYCLES-1 with samp==samp_d.
- Latency: an input change present before edge E0 yields valid high during the cycle after edge E0+STABLE_CYCLES.
- States:
  - IDLE: nothing reported since reset. First accepted legal pattern always reports.
  - SETTLE: counting. Any change restarts the count.
  - HOLD: pattern accepted. Stays here until samp changes, then goes to SETTLE.
- Decoding: standard hex glyphs, with polarity inverted when ACTIVE_LOW=1:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
  - A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
  - seg_carry is legal only as glyph 0 or 1.
- Accepted legal pattern:
  - Update sum_val/carry_val and clear err.
  - Pulse valid only if the decoded pair differs from the last reported pair, or the state was IDLE, or err was set.
  - A held pattern never re-pulses valid.
- Accepted illegal pattern (either digit): err=1, valid=0, sum_val/carry_val hold their values.
- Blank on either digit: not an error and not reported. Outputs hold and err holds.
- Simultaneous events: an input change on the same edge the count would complete takes priority, so there is no acceptance. Reset overrides everything.
- A glitch shorter than STABLE_CYCLES produces no output activity. Returning to the previous stable pattern produces no new valid.

Decomposition:
- Shared package/header seg7_defs:
  - segment bit-order constants (SEG_A..SEG_G);
  - 16 hex glyph constants in active-high form;
  - BLANK constant;
  - state encoding constants IDLE/SETTLE/HOLD.
- One combinational sub-module, seg7_to_hex (inverse of the display encoder), instantiated twice:
  - inputs: pattern, polarity;
  - outputs: value[3:0], legal, blank.
- The FSM, counter and output registers live in the top module.

Test Plan:
All cases use STABLE_CYCLES=4, ACTIVE_LOW=1. Glyph codes: 0=7'h40, 1=7'h79, 2=7'h24, 8=7'h00, blank=7'h7F.
1. Release reset; drive seg_sum=7'h40, seg_carry=7'h40 -> exactly one valid pulse 5 edges after the drive edge; sum_val=0, carry_val=0, err=0.
2. Drive seg_sum=7'h00, seg_carry=7'h40, hold 20 cycles -> single valid pulse; sum_val=8, carry_val=0; no further pulses.
3. From test 2, drive seg_sum=7'h79 for 2 cycles, then return to 7'h00 -> no valid; sum_val stays 8.
4. Drive seg_sum=7'h24, seg_carry=7'h79 (1010+1000) -> one valid; sum_val=2, carry_val=1.
5. Drive seg_carry=7'h00 (glyph 8) -> err=1 after settling, valid=0, outputs hold 2/1; then drive 7'h40 -> err=0 with one valid, carry_val=0.
6. Drive a new pattern, assert reset on the 2nd settling cycle -> next cycle all outputs 0; no valid until a fresh STABLE_CYCLES window completes after release.

Source files
------------

// File: rtl/seg7_defs_pkg.sv
// Shared definitions for the 7-segment readback path: segment bit order,
// hex glyph table (active-high), blank pattern and monitor state encoding.
package seg7_defs;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Index i holds the lit-segment pattern for hex digit i (1 = segment on).
  localparam logic [6:0] HEX_GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex display encoder: maps a segment pattern
// back to its digit and flags blank or unrecognised patterns.
module seg7_to_hex
  import seg7_defs::*;
(
  input  logic [6:0] pattern,
  input  logic       polarity,
  output logic [3:0] value,
  output logic       legal,
  output logic       blank
);

  logic [6:0] lit;

  // polarity=1 means a lit segment is driven low, so normalise to active-high first.
  always_comb begin
    lit   = polarity ? ~pattern : pattern;
    blank = (lit == BLANK);
    value = 4'd0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (lit == HEX_GLYPHS[i]) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Readback monitor for the adder's sum/carry displays: debounces the segment
// buses, decodes settled patterns and reports new results or illegal glyphs.
module seg7_readback_decoder
  import seg7_defs::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_sum,
  input  logic [6:0] seg_carry,
  output logic [3:0] sum_val,
  output logic       carry_val,
  output logic       valid,
  output logic       err
);

  localparam logic [6:0]  BLANK_IN   = ACTIVE_LOW ? ~BLANK : BLANK;
  localparam logic [13:0] BLANK_PAIR = {BLANK_IN, BLANK_IN};
  localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0]  ACCEPT_AT  = (STABLE_CYCLES >= 2) ? 8'(STABLE_CYCLES - 2) : 8'd0;

  logic [13:0] samp_q, samp_d;
  logic [13:0] samp_prev_q, samp_prev_d;
  logic [7:0]  cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic [3:0]  sum_val_q, sum_val_d;
  logic        carry_val_q, carry_val_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        reported_q, reported_d;

  logic [3:0]  sum_dec, carry_dec;
  logic        sum_legal, carry_legal;
  logic        sum_blank, carry_blank;
  logic        changed;
  logic        pair_ok;

  seg7_to_hex u_sum_dec (
    .pattern  (samp_q[6:0]),
    .polarity (ACTIVE_LOW),
    .value    (sum_dec),
    .legal    (sum_legal),
    .blank    (sum_blank)
  );

  seg7_to_hex u_carry_dec (
    .pattern  (samp_q[13:7]),
    .polarity (ACTIVE_LOW),
    .value    (carry_dec),
    .legal    (carry_legal),
    .blank    (carry_blank)
  );

  // A change always wins over a count that would complete on the same edge.
  always_comb begin
    samp_d      = {seg_carry, seg_sum};
    samp_prev_d = samp_q;
    changed     = (samp_q != samp_prev_q);
    pair_ok     = sum_legal && carry_legal && (carry_dec <= 4'd1);

    cnt_d       = cnt_q;
    state_d     = state_q;
    sum_val_d   = sum_val_q;
    carry_val_d = carry_val_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    reported_d  = reported_q;

    if (changed) begin
      cnt_d   = 8'd0;
      state_d = SETTLE;
    end else begin
      if (cnt_q < STABLE_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end
      if (state_q == SETTLE && cnt_q == ACCEPT_AT) begin
        state_d = HOLD;
        if (sum_blank || carry_blank) begin
          // blank digit: nothing to report, keep previous outputs and err
        end else if (!pair_ok) begin
          err_d = 1'b1;
        end else begin
          sum_val_d   = sum_dec;
          carry_val_d = carry_dec[0];
          err_d       = 1'b0;
          reported_d  = 1'b1;
          valid_d     = !reported_q || err_q ||
                        (sum_dec != sum_val_q) || (carry_dec[0] != carry_val_q);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      samp_q      <= BLANK_PAIR;
      samp_prev_q <= BLANK_PAIR;
      cnt_q       <= 8'd0;
      state_q     <= IDLE;
      sum_val_q   <= 4'd0;
      carry_val_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      reported_q  <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      samp_prev_q <= samp_prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      sum_val_q   <= sum_val_d;
      carry_val_q <= carry_val_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      reported_q  <= reported_d;
    end
  end

  assign sum_val   = sum_val_q;
  assign carry_val = carry_val_q;
  assign valid     = valid_q;
  assign err       = err_q;

endmodule
